// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard sequencer: FSM encodings, forwarding
// select codes and the saturating counter helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_FLUSH      = 2'd2,
    HZ_MEM_WAIT   = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Remaining-cycle counter; wide enough for stall/flush lengths up to 4.
  localparam int CNT_W = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard sequencer: stage status in,
// stall/flush/redirect/forwarding controls and debug counters out.
interface hazard_ctrl_if;

  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_writes_reg;
  logic [4:0]  ex_dest;
  logic        mem_valid;
  logic        mem_writes_reg;
  logic [4:0]  mem_dest;
  logic        mem_busy;
  logic        bt;
  logic [31:0] bt_target;

  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        flush_ifid;
  logic        flush_idex;
  logic        pipe_hold;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic [1:0]  fwd_rs;
  logic [1:0]  fwd_rt;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_valid, ex_is_load, ex_writes_reg, ex_dest,
           mem_valid, mem_writes_reg, mem_dest, mem_busy, bt, bt_target,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, pipe_hold,
           pc_sel, pc_target, fwd_rs, fwd_rt, state, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_valid, ex_is_load, ex_writes_reg, ex_dest,
           mem_valid, mem_writes_reg, mem_dest, mem_busy, bt, bt_target,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, pipe_hold,
           pc_sel, pc_target, fwd_rs, fwd_rt, state, stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// ALU operand forwarding select for one source register; the younger EX
// result wins over MEM, and r0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ex_valid,
  input  logic       ex_writes_reg,
  input  logic [4:0] ex_dest,
  input  logic       mem_valid,
  input  logic       mem_writes_reg,
  input  logic [4:0] mem_dest,
  output logic [1:0] sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_valid && ex_writes_reg && (ex_dest != 5'd0) && (ex_dest == src);
  assign mem_hit = mem_valid && mem_writes_reg && (mem_dest != 5'd0) && (mem_dest == src);
  assign sel     = ex_hit ? FWD_EX : (mem_hit ? FWD_MEM : FWD_REG);

endmodule

// File: rtl/hazard_ctrl.sv
// EX-stage pipeline sequencer: load-use bubbles, taken-branch flushes,
// data-memory freeze with pending-branch capture, forwarding and counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_DEPTH       = 2
) (
  input  logic        clock,
  input  logic        reset,
  hazard_ctrl_if.slave hz
);

  hz_state_e          state_reg, state_next;
  hz_state_e          ret_reg, ret_next;
  hz_state_e          eff_state;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pend_bt_reg, pend_bt_next;
  logic [31:0]        pend_tgt_reg, pend_tgt_next;
  logic [31:0]        stall_cnt_reg, stall_cnt_next;
  logic [31:0]        flush_cnt_reg, flush_cnt_next;

  logic               hazard;
  logic               branch_req;
  logic               pc_write_c, ifid_write_c, idex_bubble_c, flush_c, pipe_hold_c, pc_sel_c;
  logic [31:0]        pc_target_c;
  logic               branch_taken;

  logic [4:0]         fwd_src [2];
  logic [1:0]         fwd_out [2];

  assign hazard = hz.ex_valid && hz.ex_is_load && (hz.ex_dest != 5'd0) && hz.id_valid &&
                  ((hz.id_uses_rs && (hz.id_rs == hz.ex_dest)) ||
                   (hz.id_uses_rt && (hz.id_rt == hz.ex_dest)));

  assign branch_req = hz.bt || pend_bt_reg;

  // While frozen the FSM keeps its saved state; the cycle busy drops acts as that state.
  assign eff_state = (state_reg == HZ_MEM_WAIT) ? ret_reg : state_reg;

  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    cnt_next       = cnt_reg;
    pend_bt_next   = pend_bt_reg;
    pend_tgt_next  = pend_tgt_reg;
    pc_write_c     = 1'b1;
    ifid_write_c   = 1'b1;
    idex_bubble_c  = 1'b0;
    flush_c        = 1'b0;
    pipe_hold_c    = 1'b0;
    pc_sel_c       = 1'b0;
    pc_target_c    = 32'd0;
    branch_taken   = 1'b0;

    if (hz.mem_busy) begin
      pipe_hold_c  = 1'b1;
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      state_next   = HZ_MEM_WAIT;
      ret_next     = eff_state;
      // Flush bubbles cannot branch, so a bt seen under a flush is not captured.
      if (hz.bt && !pend_bt_reg && (eff_state != HZ_FLUSH)) begin
        pend_bt_next  = 1'b1;
        pend_tgt_next = hz.bt_target;
      end
    end else if (eff_state == HZ_FLUSH) begin
      flush_c = 1'b1;
      if (cnt_reg <= CNT_W'(1)) begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end else begin
        state_next = HZ_FLUSH;
        cnt_next   = cnt_reg - CNT_W'(1);
      end
    end else if (branch_req) begin
      pc_sel_c     = 1'b1;
      pc_target_c  = pend_bt_reg ? pend_tgt_reg : hz.bt_target;
      flush_c      = 1'b1;
      branch_taken = 1'b1;
      pend_bt_next = 1'b0;
      if (FLUSH_DEPTH > 1) begin
        state_next = HZ_FLUSH;
        cnt_next   = CNT_W'(FLUSH_DEPTH - 1);
      end else begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end
    end else if (eff_state == HZ_LOAD_STALL) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      if (cnt_reg <= CNT_W'(1)) begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end else begin
        state_next = HZ_LOAD_STALL;
        cnt_next   = cnt_reg - CNT_W'(1);
      end
    end else if (hazard) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_next = HZ_LOAD_STALL;
        cnt_next   = CNT_W'(LOAD_STALL_CYCLES - 1);
      end else begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end
    end else begin
      state_next = HZ_RUN;
    end

    stall_cnt_next = pc_write_c ? stall_cnt_reg : sat_inc(stall_cnt_reg);
    flush_cnt_next = branch_taken ? sat_inc(flush_cnt_reg) : flush_cnt_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= HZ_RUN;
      ret_reg       <= HZ_RUN;
      cnt_reg       <= '0;
      pend_bt_reg   <= 1'b0;
      pend_tgt_reg  <= 32'd0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      ret_reg       <= ret_next;
      cnt_reg       <= cnt_next;
      pend_bt_reg   <= pend_bt_next;
      pend_tgt_reg  <= pend_tgt_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign fwd_src[0] = hz.id_rs;
  assign fwd_src[1] = hz.id_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    hazard_ctrl_fwd_sel u_fwd_sel (
      .src            (fwd_src[gi]),
      .ex_valid       (hz.ex_valid),
      .ex_writes_reg  (hz.ex_writes_reg),
      .ex_dest        (hz.ex_dest),
      .mem_valid      (hz.mem_valid),
      .mem_writes_reg (hz.mem_writes_reg),
      .mem_dest       (hz.mem_dest),
      .sel            (fwd_out[gi])
    );
  end

  // Reset forces the idle control pattern combinationally, not just after the next edge.
  assign hz.pc_write     = reset | pc_write_c;
  assign hz.ifid_write   = reset | ifid_write_c;
  assign hz.idex_bubble  = !reset && idex_bubble_c;
  assign hz.flush_ifid   = !reset && flush_c;
  assign hz.flush_idex   = !reset && flush_c;
  assign hz.pipe_hold    = !reset && pipe_hold_c;
  assign hz.pc_sel       = !reset && pc_sel_c;
  assign hz.pc_target    = reset ? 32'd0 : pc_target_c;
  assign hz.fwd_rs       = reset ? FWD_REG : fwd_out[0];
  assign hz.fwd_rt       = reset ? FWD_REG : fwd_out[1];
  assign hz.state        = state_reg;
  assign hz.stall_cycles = stall_cnt_reg;
  assign hz.flush_events = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: instance 0 uses default
// parameters, instance 1 uses LOAD_STALL_CYCLES=3; both see the same stimulus.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        flush_ifid;
    logic        flush_idex;
    logic        pipe_hold;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [1:0]  state;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
  } obs_t;

  typedef struct {
    int    dut;
    string name;
    obs_t  exp;
  } sb_entry_t;

  logic        clock = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs, id_rt, ex_dest, mem_dest;
  logic        ex_valid, ex_is_load, ex_writes_reg;
  logic        mem_valid, mem_writes_reg, mem_busy, bt;
  logic [31:0] bt_target;

  obs_t        obs [2];
  sb_entry_t   sb [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    hazard_ctrl_if hz_if ();

    hazard_ctrl #(
      .LOAD_STALL_CYCLES (gi == 0 ? 1 : 3),
      .FLUSH_DEPTH       (2)
    ) u_dut (
      .clock (clock),
      .reset (rst),
      .hz    (hz_if)
    );

    assign hz_if.id_valid       = id_valid;
    assign hz_if.id_rs          = id_rs;
    assign hz_if.id_rt          = id_rt;
    assign hz_if.id_uses_rs     = id_uses_rs;
    assign hz_if.id_uses_rt     = id_uses_rt;
    assign hz_if.ex_valid       = ex_valid;
    assign hz_if.ex_is_load     = ex_is_load;
    assign hz_if.ex_writes_reg  = ex_writes_reg;
    assign hz_if.ex_dest        = ex_dest;
    assign hz_if.mem_valid      = mem_valid;
    assign hz_if.mem_writes_reg = mem_writes_reg;
    assign hz_if.mem_dest       = mem_dest;
    assign hz_if.mem_busy       = mem_busy;
    assign hz_if.bt             = bt;
    assign hz_if.bt_target      = bt_target;

    assign obs[gi] = {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_bubble, hz_if.flush_ifid,
                      hz_if.flush_idex, hz_if.pipe_hold, hz_if.pc_sel, hz_if.pc_target,
                      hz_if.fwd_rs, hz_if.fwd_rt, hz_if.state, hz_if.stall_cycles,
                      hz_if.flush_events};
  end

  function automatic obs_t mk(bit pcw, bit ifw, bit bub, bit fl, bit hold, bit psel,
                              logic [31:0] tgt, logic [1:0] frs, logic [1:0] frt,
                              hz_state_e st, int sc, int fe);
    obs_t o;
    o.pc_write     = pcw;
    o.ifid_write   = ifw;
    o.idex_bubble  = bub;
    o.flush_ifid   = fl;
    o.flush_idex   = fl;
    o.pipe_hold    = hold;
    o.pc_sel       = psel;
    o.pc_target    = tgt;
    o.fwd_rs       = frs;
    o.fwd_rt       = frt;
    o.state        = st;
    o.stall_cycles = 32'(sc);
    o.flush_events = 32'(fe);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pcw=%0b ifw=%0b bub=%0b fl=%0b%0b hold=%0b psel=%0b tgt=%h frs=%0d frt=%0d st=%0d sc=%0d fe=%0d",
                     o.pc_write, o.ifid_write, o.idex_bubble, o.flush_ifid, o.flush_idex,
                     o.pipe_hold, o.pc_sel, o.pc_target, o.fwd_rs, o.fwd_rt, o.state,
                     o.stall_cycles, o.flush_events);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(int dut, string name, obs_t e);
    sb_entry_t s;
    s.dut  = dut;
    s.name = name;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
    ex_valid = 0; ex_is_load = 0; ex_writes_reg = 0; ex_dest = 0;
    mem_valid = 0; mem_writes_reg = 0; mem_dest = 0; mem_busy = 0;
    bt = 0; bt_target = 32'd0;
  endtask

  // LW r8 in EX, consumer reading r8 (rs) and r9 (rt) in ID.
  task automatic lw_hazard();
    idle();
    ex_valid = 1; ex_is_load = 1; ex_writes_reg = 1; ex_dest = 5'd8;
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd8; id_uses_rt = 1; id_rt = 5'd9;
  endtask

  // Consumer still waiting in ID while EX holds a bubble.
  task automatic id_only();
    idle();
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd8; id_uses_rt = 1; id_rt = 5'd9;
  endtask

  // Scoreboard monitor: compares whatever expectation is pending for this cycle.
  initial begin
    sb_entry_t e;
    obs_t      act;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = obs[e.dut];
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s dut%0d: got %s | expected %s", e.name, e.dut, fmt(act), fmt(e.exp));
        end else begin
          $display("[%0t] chk %-20s dut%0d ok  %s", $time, e.name, e.dut, fmt(act));
        end
      end
    end
  end

  initial begin
    rst = 1;
    idle();
    tick();

    // ---- instance 0: reset, load-use, forwarding
    push(0, "reset",            mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 0,0)); tick();
    rst = 0;
    push(0, "idle",             mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 0,0)); tick();
    lw_hazard();
    push(0, "lu_stall",         mk(0,0,1,0,0,0, 32'd0, 2'b01,2'b00, HZ_RUN, 0,0)); tick();
    id_only(); mem_valid = 1; mem_writes_reg = 1; mem_dest = 5'd8;
    push(0, "lu_fwd_mem",       mk(1,1,0,0,0,0, 32'd0, 2'b10,2'b00, HZ_RUN, 1,0)); tick();
    idle(); id_valid = 1; id_uses_rs = 1; id_rs = 5'd9; id_uses_rt = 1; id_rt = 5'd5;
    ex_valid = 1; ex_writes_reg = 1; ex_dest = 5'd9;
    mem_valid = 1; mem_writes_reg = 1; mem_dest = 5'd9;
    push(0, "fwd_ex_beats_mem", mk(1,1,0,0,0,0, 32'd0, 2'b01,2'b00, HZ_RUN, 1,0)); tick();
    idle(); ex_valid = 1; ex_is_load = 1; ex_writes_reg = 1; ex_dest = 5'd0;
    mem_valid = 1; mem_writes_reg = 1; mem_dest = 5'd0;
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd0;
    push(0, "r0_no_stall_fwd",  mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 1,0)); tick();
    lw_hazard(); id_uses_rs = 0; id_uses_rt = 0;
    push(0, "unused_src",       mk(1,1,0,0,0,0, 32'd0, 2'b01,2'b00, HZ_RUN, 1,0)); tick();

    // ---- instance 0: taken branch, bt during FLUSH ignored
    idle(); bt = 1; bt_target = 32'h0040_0020;
    push(0, "bt_take",          mk(1,1,0,1,0,1, 32'h0040_0020, 2'b00,2'b00, HZ_RUN, 1,0)); tick();
    bt_target = 32'h0000_0099;
    push(0, "bt_flush2",        mk(1,1,0,1,0,0, 32'd0, 2'b00,2'b00, HZ_FLUSH, 1,1)); tick();
    idle();
    push(0, "bt_done",          mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 1,1)); tick();

    // ---- instance 0: 3-cycle memory wait, bt on 2nd (first wins over 3rd)
    idle(); mem_busy = 1;
    push(0, "mw1",              mk(0,0,0,0,1,0, 32'd0, 2'b00,2'b00, HZ_RUN, 1,1)); tick();
    bt = 1; bt_target = 32'h0000_1234;
    push(0, "mw2_bt",           mk(0,0,0,0,1,0, 32'd0, 2'b00,2'b00, HZ_MEM_WAIT, 2,1)); tick();
    bt_target = 32'hDEAD_0000;
    push(0, "mw3_bt_ignored",   mk(0,0,0,0,1,0, 32'd0, 2'b00,2'b00, HZ_MEM_WAIT, 3,1)); tick();
    idle();
    push(0, "mw_release_br",    mk(1,1,0,1,0,1, 32'h0000_1234, 2'b00,2'b00, HZ_MEM_WAIT, 4,1)); tick();
    push(0, "mw_flush2",        mk(1,1,0,1,0,0, 32'd0, 2'b00,2'b00, HZ_FLUSH, 4,2)); tick();
    push(0, "mw_done",          mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 4,2)); tick();

    // ---- instance 1 (3 bubbles): full stall, then stall aborted by bt
    rst = 1;
    push(1, "b_reset",          mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 0,0)); tick();
    rst = 0;
    lw_hazard();
    push(1, "b_stall1",         mk(0,0,1,0,0,0, 32'd0, 2'b01,2'b00, HZ_RUN, 0,0)); tick();
    id_only();
    push(1, "b_stall2",         mk(0,0,1,0,0,0, 32'd0, 2'b00,2'b00, HZ_LOAD_STALL, 1,0)); tick();
    push(1, "b_stall3",         mk(0,0,1,0,0,0, 32'd0, 2'b00,2'b00, HZ_LOAD_STALL, 2,0)); tick();
    push(1, "b_stall_done",     mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 3,0)); tick();
    lw_hazard();
    push(1, "b_abort_stall1",   mk(0,0,1,0,0,0, 32'd0, 2'b01,2'b00, HZ_RUN, 3,0)); tick();
    id_only(); bt = 1; bt_target = 32'h0040_0020;
    push(1, "b_abort_bt",       mk(1,1,0,1,0,1, 32'h0040_0020, 2'b00,2'b00, HZ_LOAD_STALL, 4,0)); tick();
    id_only();
    push(1, "b_abort_flush2",   mk(1,1,0,1,0,0, 32'd0, 2'b00,2'b00, HZ_FLUSH, 4,1)); tick();
    push(1, "b_no_residual",    mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 4,1)); tick();

    // ---- instance 0: reset asserted mid-flush
    idle(); rst = 1; tick();
    rst = 0; bt = 1; bt_target = 32'h0040_0020;
    push(0, "f_bt",             mk(1,1,0,1,0,1, 32'h0040_0020, 2'b00,2'b00, HZ_RUN, 0,0)); tick();
    idle(); rst = 1;
    push(0, "rst_mid_flush",    mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 0,0)); tick();
    rst = 0;
    push(0, "post_rst_clean",   mk(1,1,0,0,0,0, 32'd0, 2'b00,2'b00, HZ_RUN, 0,0)); tick();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
